xnor_gate_using_mux: RTL and testbench
======================================

# xnor_gate_using_mux

Bitwise XNOR block in which every output bit is built from a 2:1 multiplexer: operand `a` selects between `b` and `~b`. It provides a combinational result path for equality and parity logic, plus a registered copy and an all-bits-equal flag for pipelined consumers. It sits in the datapath utility layer and has no handshake with neighbours beyond a capture enable.

## Interface
- `WIDTH`, default 1: operand width in bits; legal range is 1..64.
- `CNT_W`, default 8: match-counter width; used only with `XNOR_MUX_MATCH_CNT_EN`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `a`, input, WIDTH: mux select operand.
- `b`, input, WIDTH: mux data operand.
- `en`, input, 1: capture enable for the registered outputs.
- `y`, output, WIDTH: combinational result, `a XNOR b` per bit.
- `match`, output, 1: combinational; 1 when `a == b` across all bits.
- `y_q`, output, WIDTH: registered `y`.
- `match_q`, output, 1: registered `match`.
- `match_cnt`, output, CNT_W: saturating count of captured matches; present only with `XNOR_MUX_MATCH_CNT_EN`.

## Operation
- Each bit `i` is formed by a 2:1 mux with select `a[i]`: input 0 is `~b[i]`, input 1 is `b[i]`. The result is `y[i] = a[i] ? b[i] : ~b[i]`.
- Truth table per bit:
  - `a=0, b=0` gives `y=1`.
  - `a=0, b=1` gives `y=0`.
  - `a=1, b=0` gives `y=0`.
  - `a=1, b=1` gives `y=1`.
- `match` is the AND-reduction of `y`.
- `y` and `match` are pure combinations of `a` and `b`. They do not depend on `clk`, `rst_n` or `en`, and stay valid while reset is asserted.
- X or Z on an input bit propagates as X on the corresponding `y` bit; no masking is done.

## Timing
- `y` and `match`: zero-cycle latency, purely combinational.
- `y_q` and `match_q`: one-cycle latency.
  - At a rising edge of `clk` with `en=1`, they load `y` and `match`.
  - With `en=0`, they hold their value.
- Reset (`rst_n=0`, asynchronous): `y_q=0`, `match_q=0`, `match_cnt=0` immediately, independent of `clk`. Registers resume at the first rising edge after `rst_n` deasserts.
- If reset asserts in the same cycle as a capture, reset wins.
- `match_cnt` behaviour:
  - Increments by 1 at each rising edge where `en=1` and `match=1`.
  - Saturates at 2^CNT_W−1; it never wraps.
  - Holds when `en=0` or `match=0`.

## Configuration
- `XNOR_MUX_MATCH_CNT_EN` defined: the `match_cnt` port and its counter are compiled in, with the behaviour above.
- `XNOR_MUX_MATCH_CNT_EN` undefined: the `match_cnt` port and counter logic are absent. All other ports and behaviour are identical.

## Structure
- Package `xnor_mux_pkg` holds:
  - `XNOR_MUX_WIDTH_DEF` = 1
  - `XNOR_MUX_CNT_W_DEF` = 8
  - typedef `xnor_cnt_t` (logic [XNOR_MUX_CNT_W_DEF-1:0])
- Sub-module `mux2`: a 1-bit 2:1 multiplexer with ports `d0`, `d1`, `sel`, `y`. It is instantiated WIDTH times in a generate loop with `d0=~b[i]`, `d1=b[i]`, `sel=a[i]`.
- Registers live in a single `always_ff` sensitive to `posedge clk or negedge rst_n`.

## Test plan
- WIDTH=1, drive `a,b` = 00, 01, 10, 11 with 10 time units each and no clock → `y` = 1, 0, 0, 1 and `match` = 1, 0, 0, 1.
- WIDTH=8, `a=8'hA5`, `b=8'hA5` → `y=8'hFF`, `match=1`. Then `b=8'h5A` → `y=8'h00`, `match=0`.
- WIDTH=8, `en=1`, `a=8'h0F`, `b=8'h0E`, one `clk` edge → `y_q=8'hFE`, `match_q=0`. Then `en=0`, change `b` to `8'h0F`, one edge → `y_q` still `8'hFE`.
- Assert `rst_n=0` between clock edges while `y_q=8'hFE` → `y_q=0` and `match_q=0` without waiting for a clock edge, while combinational `y` still follows `a` and `b`.
- `XNOR_MUX_MATCH_CNT_EN`, CNT_W=2, `a=b`, `en=1` for 5 edges → `match_cnt` = 1, 2, 3, 3, 3.
- `XNOR_MUX_MATCH_CNT_EN`, `a≠b`, `en=1` for 3 edges after reset → `match_cnt` stays 0.

Source files
------------

// File: rtl/xnor_mux_pkg.sv
// Shared defaults and types for the mux-built XNOR block.
package xnor_mux_pkg;
    localparam int XNOR_MUX_WIDTH_DEF = 1;
    localparam int XNOR_MUX_CNT_W_DEF = 8;

    typedef logic [XNOR_MUX_CNT_W_DEF-1:0] xnor_cnt_t;
endpackage

// File: rtl/xnor_gate_using_mux_mux2.sv
// One-bit 2:1 multiplexer; sel=1 picks d1.
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/xnor_gate_using_mux.sv
// Bitwise XNOR from per-bit 2:1 muxes, with a registered copy and all-equal flag.
// Define XNOR_MUX_MATCH_CNT_EN to add the saturating match_cnt port and counter.
module xnor_gate_using_mux
    import xnor_mux_pkg::*;
#(
    parameter int WIDTH = XNOR_MUX_WIDTH_DEF,
    parameter int CNT_W = XNOR_MUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             match,
    output logic [WIDTH-1:0] y_q,
    output logic             match_q
`ifdef XNOR_MUX_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
        $error("xnor_gate_using_mux: WIDTH must be 1..64 and CNT_W >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2 u_mux2 (
            .d0  (~b[i]),
            .d1  (b[i]),
            .sel (a[i]),
            .y   (y[i])
        );
    end

    assign match = &y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            match_q   <= 1'b0;
`ifdef XNOR_MUX_MATCH_CNT_EN
            match_cnt <= '0;
`endif
        end else if (en) begin
            y_q     <= y;
            match_q <= match;
`ifdef XNOR_MUX_MATCH_CNT_EN
            // Saturate rather than wrap so a long run of matches never reads as few.
            if (match && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + CNT_W'(1);
`endif
        end
    end

endmodule

// File: tb/tb_xnor_gate_using_mux.sv
// Directed bench for xnor_gate_using_mux: truth tables, capture/hold, async reset, match counter.
module tb_xnor_gate_using_mux;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       m;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b, y, y_q;
    logic       en, match, match_q;
    logic [0:0] a1, b1, y1, y1_q;
    logic       en1, match1, match1_q;
`ifdef XNOR_MUX_MATCH_CNT_EN
    logic [1:0] match_cnt;
    logic [7:0] match1_cnt;
`endif

    int errors = 0;
    int checks = 0;

    xnor_gate_using_mux #(.WIDTH(8), .CNT_W(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .en        (en),
        .y         (y),
        .match     (match),
        .y_q       (y_q),
        .match_q   (match_q)
`ifdef XNOR_MUX_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    xnor_gate_using_mux #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .en        (en1),
        .y         (y1),
        .match     (match1),
        .y_q       (y1_q),
        .match_q   (match1_q)
`ifdef XNOR_MUX_MATCH_CNT_EN
        ,
        .match_cnt (match1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8'hFF, 1'b1};
        vecs[1] = '{8'hA5, 8'h5A, 8'h00, 1'b0};
        vecs[2] = '{8'h0F, 8'h0E, 8'hFE, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 8'hD9, 1'b0};
        vecs[7] = '{8'h80, 8'h00, 8'h7F, 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        en1   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        a1    = 1'b0;
        b1    = 1'b0;
        #1;
        chk("reset_y_q", 64'(y_q), 64'h0);
        chk("reset_match_q", 64'(match_q), 64'h0);
`ifdef XNOR_MUX_MATCH_CNT_EN
        chk("reset_match_cnt", 64'(match_cnt), 64'h0);
`endif

        // WIDTH=1 truth table, combinational only
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            #10;
            chk("w1_y", 64'(y1), 64'((i == 0 || i == 3) ? 1 : 0));
            chk("w1_match", 64'(match1), 64'((i == 0 || i == 3) ? 1 : 0));
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_y", i), 64'(y), 64'(vecs[i].y));
            chk($sformatf("vec%0d_match", i), 64'(match), 64'(vecs[i].m));
            chk($sformatf("vec%0d_y_q_in_reset", i), 64'(y_q), 64'h0);
        end

        // capture a match, then a mismatch, then hold
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        a = 8'h3C;
        b = 8'h3C;
        @(posedge clk);
        #1;
        chk("cap_eq_y_q", 64'(y_q), 64'hFF);
        chk("cap_eq_match_q", 64'(match_q), 64'h1);
        @(negedge clk);
        a = 8'h0F;
        b = 8'h0E;
        @(posedge clk);
        #1;
        chk("cap_ne_y_q", 64'(y_q), 64'hFE);
        chk("cap_ne_match_q", 64'(match_q), 64'h0);
        @(negedge clk);
        en = 1'b0;
        b = 8'h0F;
        @(posedge clk);
        #1;
        chk("hold_y_q", 64'(y_q), 64'hFE);
        chk("hold_match_q", 64'(match_q), 64'h0);
        chk("hold_comb_match", 64'(match), 64'h1);

        // async reset between edges; comb path keeps following inputs
        #2;
        rst_n = 1'b0;
        a = 8'hC3;
        b = 8'h3C;
        #1;
        chk("async_rst_y_q", 64'(y_q), 64'h0);
        chk("async_rst_match_q", 64'(match_q), 64'h0);
        chk("rst_comb_y", 64'(y), 64'h00);
        b = 8'hC3;
        #1;
        chk("rst_comb_y_eq", 64'(y), 64'hFF);
        chk("rst_comb_match", 64'(match), 64'h1);

        // matches with en=1 for five edges: counter saturates at 3
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        a = 8'h55;
        b = 8'h55;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("run_eq%0d_match_q", k), 64'(match_q), 64'h1);
`ifdef XNOR_MUX_MATCH_CNT_EN
            chk($sformatf("cnt_sat%0d", k), 64'(match_cnt), 64'((k < 3) ? k : 3));
`endif
        end

        // mismatches after reset: counter stays at 0
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        b = 8'h54;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("run_ne%0d_y_q", k), 64'(y_q), 64'hFE);
            chk($sformatf("run_ne%0d_match_q", k), 64'(match_q), 64'h0);
`ifdef XNOR_MUX_MATCH_CNT_EN
            chk($sformatf("cnt_ne%0d", k), 64'(match_cnt), 64'h0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
